// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_ctrl
// Brief    : PC / fetch-side controller. Takes the ID-stage branch decision,
//            computes the redirect target, steers the PC, squashes the
//            wrong-path fetch and counts accepted redirects (saturating).
// Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_ctrl #(
    parameter logic [63:0] RESET_VECTOR = 64'h0,
    parameter int          CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             stall,
    input  logic             br_valid,
    input  logic             BrTaken,
    input  logic             UncondBr,
    input  logic             pc_rd,
    input  logic [63:0]      br_pc,
    input  logic [25:0]      imm26,
    input  logic [18:0]      imm19,
    input  logic [63:0]      reg_target,
    output logic [63:0]      pc,
    output logic [63:0]      pc_plus4,
    output logic             if_valid,
    output logic             if_flush,
    output logic [CNT_W-1:0] redirect_count
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PEND  = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state, w_state_nxt;
    logic [63:0]      r_pc, w_pc_nxt;
    logic [63:0]      r_pend, w_pend_nxt;
    logic             r_flush, w_flush_nxt;
    logic             r_valid, w_valid_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             w_cnt_inc;

    logic             w_redirect;
    logic [63:0]      w_off26, w_off19, w_target, w_pc_plus4;

    // Redirect request and target: register target beats both immediates
    assign w_redirect = br_valid & (BrTaken | pc_rd);
    assign w_off26    = {{36{imm26[25]}}, imm26, 2'b00};
    assign w_off19    = {{43{imm19[18]}}, imm19, 2'b00};
    assign w_target   = pc_rd ? reg_target
                              : (br_pc + (UncondBr ? w_off26 : w_off19));
    assign w_pc_plus4 = r_pc + 64'd4;

    assign pc             = r_pc;
    assign pc_plus4       = w_pc_plus4;
    assign if_valid       = r_valid;
    assign if_flush       = r_flush;
    assign redirect_count = r_cnt;

    // State, PC, pending target and counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_BOOT;
            r_pc    <= RESET_VECTOR;
            r_pend  <= 64'd0;
            r_flush <= 1'b0;
            r_valid <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_pend  <= w_pend_nxt;
            r_flush <= w_flush_nxt;
            r_valid <= w_valid_nxt;
            if (w_cnt_inc && (r_cnt != c_CNT_MAX)) begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
        end
    end

    // Next-state and next-PC decode; branch inputs only matter in RUN
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_pend_nxt  = r_pend;
        w_flush_nxt = r_flush;
        w_valid_nxt = r_valid;
        w_cnt_inc   = 1'b0;
        case (r_state)
            ST_BOOT: begin
                // First live fetch is at the reset vector itself
                w_state_nxt = ST_RUN;
                w_valid_nxt = 1'b1;
            end
            ST_RUN: begin
                if (w_redirect) begin
                    if (stall) begin
                        // Remember the target until the stall lifts
                        w_pend_nxt  = w_target;
                        w_state_nxt = ST_PEND;
                    end else begin
                        w_pc_nxt    = w_target;
                        w_flush_nxt = 1'b1;
                        w_cnt_inc   = 1'b1;
                        w_state_nxt = ST_FLUSH;
                    end
                end else if (!stall) begin
                    w_pc_nxt = w_pc_plus4;
                end
            end
            ST_PEND: begin
                if (!stall) begin
                    w_pc_nxt    = r_pend;
                    w_flush_nxt = 1'b1;
                    w_cnt_inc   = 1'b1;
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // Inputs here belong to the squashed instruction
                if (!stall) begin
                    w_pc_nxt    = w_pc_plus4;
                    w_flush_nxt = 1'b0;
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_BOOT;
                w_flush_nxt = 1'b0;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- PC/fetch-side controller for the pipelined ARM core.
- Consumes the branch decision (BrTaken, UncondBr, pc_rd) for the instruction in ID.
- Computes the redirect target, updates the PC, and squashes the wrong-path instruction in IF.
- Handles pipeline stalls, including a branch that resolves while stalled, and keeps a saturating count of taken redirects.

Parameters:
- RESET_VECTOR, 64'h0: PC value loaded on reset.
- CNT_W, 32: width of redirect_count.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- stall  in  1  hold PC/fetch this cycle (hazard unit)
- br_valid  in  1  ID-stage instruction is valid
- BrTaken  in  1  conditional or unconditional branch taken
- UncondBr  in  1  1 = use imm26 (B/BL), 0 = use imm19 (B.cond/CBZ)
- pc_rd  in  1  BR: target comes from reg_target
- br_pc  in  64  PC of the ID-stage instruction
- imm26  in  26  BR_address field
- imm19  in  19  COND_BR_address field
- reg_target  in  64  register value for BR
- pc  out  64  current fetch address
- pc_plus4  out  64  pc + 4, combinational
- if_valid  out  1  fetch at pc is live
- if_flush  out  1  squash the instruction entering IF/ID
- redirect_count  out  CNT_W  accepted redirects, saturating

Behaviour:
- Reset (async, reset_n=0):
  - pc=RESET_VECTOR, if_valid=0, if_flush=0, redirect_count=0, pending target=0, state=BOOT.
  - Asserting reset mid-operation discards any pending or flushing state immediately.
- Redirect request: r = br_valid & (BrTaken | pc_rd).
- Target selection, in priority order:
  - pc_rd=1: reg_target.
  - else UncondBr=1: br_pc + (sext(imm26)<<2).
  - else: br_pc + (sext(imm19)<<2).
  - All additions are modulo 2^64. pc_plus4 wraps the same way (64'hFFFF_FFFF_FFFF_FFFC -> 0).
- States and transitions, all on rising clk:
  - BOOT: pc held, if_valid=0. Next edge -> RUN with if_valid=1 and pc unchanged, so the first fetch is at RESET_VECTOR. stall is ignored in BOOT.
  - RUN, r=0, stall=0: pc <= pc+4.
  - RUN, r=0, stall=1: pc held.
  - RUN, r=1, stall=0: pc <= target, if_flush <= 1, redirect_count++ (saturating), -> FLUSH.
  - RUN, r=1, stall=1: pending <= target, pc held, -> PEND.
  - PEND: branch inputs ignored; pc held while stall=1. On the first edge with stall=0: pc <= pending, if_flush <= 1, redirect_count++, -> FLUSH.
  - FLUSH: if_flush=1; branch inputs ignored (they belong to the squashed instruction).
    - stall=1: pc held, remain in FLUSH, if_flush stays 1.
    - stall=0: pc <= pc+4, if_flush <= 0, -> RUN.
- Output timing:
  - if_flush is registered, high exactly in FLUSH.
  - if_valid=1 in RUN, PEND and FLUSH.
- Latency: a redirect accepted at edge N puts the target on pc after edge N. The next sequential pc follows edge N+1 if unstalled.
- redirect_count saturates at 2^CNT_W-1 and never wraps.
- BrTaken=1 and pc_rd=1 together: pc_rd wins, counted once.
- br_valid=0: BrTaken, UncondBr and pc_rd are don't-care; no redirect.

Test Plan:
- Reset with RESET_VECTOR=64'h100, release, 4 unstalled cycles -> BOOT, then pc=100 with if_valid=1, then 104, 108, 10C; if_flush stays 0.
- In RUN at pc=200: br_pc=1F8, BrTaken=1, UncondBr=0, imm19=19'h7FFFE (-2) -> pc=1F0 next cycle, if_flush=1 for one cycle, then pc=1F4; redirect_count=1.
- br_pc=40, UncondBr=1, BrTaken=1, imm26=26'h10 -> pc=80. Then pc_rd=1, BrTaken=1, reg_target=DEAD0 -> pc=DEAD0, which confirms pc_rd priority; count increments by 1 per redirect.
- stall=1 together with a B (target 300), held 3 cycles, then stall=0 -> PEND; pc held and if_flush=0 during the stall; pc=300 after release with a one-cycle if_flush; a br_valid pulse during PEND is ignored.
- CNT_W=2, five redirects -> redirect_count 1, 2, 3, 3, 3.
- Assert reset_n=0 asynchronously mid-FLUSH, then sequential fetch from pc=64'hFFFF_FFFF_FFFF_FFF8 -> outputs reset immediately with no clock edge; sequence ...FFF8 -> ...FFFC -> 0 (wrap).
